pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder.sv | 159 +++++++++++++++
 tb/tb_pipelined_adder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract with carry-in. The ripple carry
// chain is cut into STAGES chunks of CHUNK bits. Each chunk has its own
// register rank. Valid/ready handshakes sit on both sides. A stage may
// load whenever it is empty or its content is moving on, so bubbles collapse
// and a full pipeline sustains one operation per cycle.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  // Subtraction is a + ~b + ~cin. cout then reads as "no borrow".
  logic [WIDTH-1:0] beff;
  logic             ceff;

  assign beff = sub ? ~b : b;
  assign ceff = sub ? ~cin : cin;

  // One valid bit per stage, and the "stage k may load" flags.
  logic [STAGES-1:0] v_all;
  logic [STAGES-1:0] load_c;
  logic              chain_nxt;

  // Ready ripples backwards from out_ready. A stage can load when it is
  // empty, or when the stage after it can take its current content.
  always_comb begin
    load_c    = '0;
    chain_nxt = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load_c[k] = !v_all[k] || chain_nxt;
      chain_nxt = load_c[k];
    end
  end

  // No operand is accepted while reset is held.
  assign in_ready = !reset && load_c[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // LO: lowest result bit this stage produces.
    // IREM: operand bits still unconsumed on entry to the stage.
    // RW: result bits known after this stage.
    localparam int LO   = gi * CHUNK;
    localparam int IREM = WIDTH - LO;
    localparam int RW   = LO + CHUNK;

    logic [IREM-1:0] op_a;
    logic [IREM-1:0] op_b;
    logic            c_in;
    logic            v_in;
    logic [CHUNK:0]  part;
    logic [RW-1:0]   r_d;
    logic [RW-1:0]   r_q;
    logic            c_q;
    logic            v_q;
    logic            take;

    if (gi == 0) begin : g_src
      assign op_a = a;
      assign op_b = beff;
      assign c_in = ceff;
      assign v_in = in_valid;
      assign r_d  = part[CHUNK-1:0];
    end else begin : g_src
      // Upper operand bits, including the sign bits needed for overflow,
      // are carried along in the previous stage's remainder registers.
      assign op_a = g_stage[gi-1].g_mid.a_q;
      assign op_b = g_stage[gi-1].g_mid.b_q;
      assign c_in = g_stage[gi-1].c_q;
      assign v_in = g_stage[gi-1].v_q;
      assign r_d  = {part[CHUNK-1:0], g_stage[gi-1].r_q};
    end

    // The chunk adder for this stage works at CHUNK+1 bits, so the top bit
    // is the chunk carry.
    assign part = {1'b0, op_a[CHUNK-1:0]}
                + {1'b0, op_b[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, c_in};

    // Data registers change only when real data arrives. The outputs
    // therefore keep the last result while the pipeline idles.
    assign take = load_c[gi] && v_in;

    assign v_all[gi] = v_q;

    // Valid bit: takes the upstream valid whenever the stage loads. This
    // includes loading a bubble.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
      end else if (load_c[gi]) begin
        v_q <= v_in;
      end
    end

    // Partial result and chunk carry.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_q <= '0;
        c_q <= 1'b0;
      end else if (take) begin
        r_q <= r_d;
        c_q <= part[CHUNK];
      end
    end

    if (gi < STAGES - 1) begin : g_mid
      logic [IREM-CHUNK-1:0] a_q;
      logic [IREM-CHUNK-1:0] b_q;

      // Operand bits that later stages still need. The effective-b form is
      // used, so the subtract control does not travel down the pipe.
      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (take) begin
          a_q <= op_a[IREM-1:CHUNK];
          b_q <= op_b[IREM-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Signed overflow: the operand signs agree and the result sign differs.
      assign ovf_d = (op_a[IREM-1] == op_b[IREM-1]) && (r_d[RW-1] != op_a[IREM-1]);

      // Overflow flag, registered alongside the final sum.
      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (take) begin
          ovf_q <= ovf_d;
        end
      end

      assign y         = r_q;
      assign cout      = c_q;
      assign ovf       = ovf_q;
      assign out_valid = v_q;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: a WIDTH=8, STAGES=2 instance for the
// hand-computed cases, plus four more geometries driven with random
// handshakes against an integer reference model.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, y;

  int vectors     = 0;
  int miscompares = 0;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .ovf(ovf)
  );

  function automatic int sw(input int i);
    case (i)
      0: return 8;
      1: return 8;
      2: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int ss(input int i);
    case (i)
      0: return 1;
      1: return 8;
      2: return 4;
      default: return 4;
    endcase
  endfunction

  logic [3:0]  s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_ovf;
  logic [31:0] s_a [4];
  logic [31:0] s_b [4];
  logic [31:0] s_y [4];
  logic [33:0] expq [4][$];

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int W = sw(gi);
    localparam int S = ss(gi);
    logic [W-1:0] y_loc;
    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(s_in_valid[gi]), .in_ready(s_in_ready[gi]),
      .a(s_a[gi][W-1:0]), .b(s_b[gi][W-1:0]), .cin(s_cin[gi]), .sub(s_sub[gi]),
      .out_valid(s_out_valid[gi]), .out_ready(s_out_ready[gi]),
      .y(y_loc), .cout(s_cout[gi]), .ovf(s_ovf[gi])
    );
    assign s_y[gi] = 32'(y_loc);
  end

  // Reference model: returns {ovf, cout, y}, with y zero-extended to 32 bits.
  function automatic logic [33:0] ref_calc(input int w, input logic [31:0] fa, input logic [31:0] fb,
                                           input logic fcin, input logic fsub);
    logic [63:0] m, am, bm, s;
    logic [31:0] yy;
    logic        co, ov, ce;
    m  = (64'd1 << w) - 64'd1;
    am = {32'd0, fa} & m;
    bm = {32'd0, (fsub ? ~fb : fb)} & m;
    ce = fsub ? ~fcin : fcin;
    s  = am + bm + {63'd0, ce};
    yy = s[31:0] & m[31:0];
    co = s[w];
    ov = (am[w-1] == bm[w-1]) && (yy[w-1] != am[w-1]);
    return {ov, co, yy};
  endfunction

  // Presents one operation to an idle main DUT, with out_ready held at 1.
  // Returns the result, the latency in cycles, and whether out_valid lasted
  // exactly one cycle.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin, input logic tsub,
                        output logic [7:0] oy, output logic oc, output logic oo,
                        output int lat, output logic once);
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      #1;
    end
    if (!out_valid) lat = -1;
    oy = y; oc = cout; oo = ovf;
    @(negedge clk);
    #1;
    once = !out_valid;
    $display("op a=%h b=%h cin=%b sub=%b -> y=%h cout=%b ovf=%b lat=%0d", ta, tb_, tcin, tsub, oy, oc, oo, lat);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, need 0", in_ready);
    end
    vectors++;
    if ({out_valid, cout, ovf, y} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got out_valid=%b cout=%b ovf=%b y=%h, need all 0", out_valid, cout, ovf, y);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_in_ready: got %b, need 1", in_ready);
    end
  endtask

  task automatic test_basic;
    logic [7:0] oy;
    logic       oc, oo, once;
    int         lat;
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, oy, oc, oo, lat, once);
    vectors++;
    if ({oc, oo, oy} !== {1'b0, 1'b0, 8'h10}) begin
      miscompares++;
      $display("FAIL basic_sum: got cout=%b ovf=%b y=%h, need 0 0 10", oc, oo, oy);
    end
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d, need 2", lat);
    end
    vectors++;
    if (once !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_single_cycle: out_valid still high a cycle later");
    end
  endtask

  task automatic test_arith;
    logic [7:0] ta [9] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h10, 8'h12, 8'h80, 8'h00, 8'hFF};
    logic [7:0] tb_[9] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h01, 8'h34, 8'h80, 8'h00, 8'hFF};
    logic       tc [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       ts [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [9:0] ex [9] = '{{1'b1, 1'b0, 8'h00}, {1'b0, 1'b1, 8'h80}, {1'b0, 1'b0, 8'hFE},
                           {1'b1, 1'b1, 8'h7F}, {1'b1, 1'b0, 8'h0E}, {1'b0, 1'b0, 8'h47},
                           {1'b1, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h00}, {1'b1, 1'b0, 8'hFF}};
    logic [7:0] oy;
    logic       oc, oo, once;
    int         lat;
    for (int i = 0; i < 9; i++) begin
      run_op(ta[i], tb_[i], tc[i], ts[i], oy, oc, oo, lat, once);
      vectors++;
      if ({oc, oo, oy} !== ex[i] || lat !== 2) begin
        miscompares++;
        $display("FAIL arith[%0d]: got cout=%b ovf=%b y=%h lat=%0d, need cout=%b ovf=%b y=%h lat=2",
                 i, oc, oo, oy, lat, ex[i][9], ex[i][8], ex[i][7:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got[$];
    int         nxt = 0;
    int         cyc = 0;
    while (got.size() < 4 && cyc < 40) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc < 6);
      if (nxt < 4) begin
        in_valid = 1'b1; a = 8'(nxt + 1); b = 8'h10; cin = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc < 6) begin
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 8'h11) begin
          miscompares++;
          $display("FAIL stall_hold cyc=%0d: got in_ready=%b out_valid=%b y=%h, need 0 1 11", cyc, in_ready, out_valid, y);
        end
      end
      if (in_valid && in_ready) nxt++;
      if (out_valid && out_ready) begin
        got.push_back(y);
        $display("b2b out y=%h at cyc %0d", y, cyc);
      end
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (got.size() != 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results, need 4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== 8'(8'h11 + i)) begin
        miscompares++;
        $display("FAIL b2b_order[%0d]: got %h, need %h", i, got[i], 8'(8'h11 + i));
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_no_dup: out_valid=%b y=%h after drain, need 0", out_valid, y);
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic [7:0] oy;
    logic       oc, oo, once;
    int         lat;
    @(negedge clk);
    in_valid = 1'b1; a = 8'hF0; b = 8'h20; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    a = 8'h30; b = 8'h01;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, cout, y} !== {1'b1, 1'b1, 8'h10} || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_pre: got out_valid=%b cout=%b y=%h in_ready=%b, need 1 1 10 0", out_valid, cout, y, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if ({out_valid, cout, ovf, y} !== 11'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midflight_reset: got out_valid=%b cout=%b ovf=%b y=%h in_ready=%b, need 0 0 0 00 1",
               out_valid, cout, ovf, y, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midflight_stale: out_valid=%b y=%h after reset, need 0", out_valid, y);
      end
    end
    run_op(8'h03, 8'h04, 1'b0, 1'b0, oy, oc, oo, lat, once);
    vectors++;
    if (oy !== 8'h07 || lat !== 2) begin
      miscompares++;
      $display("FAIL midflight_new: got y=%h lat=%0d, need 07 2", oy, lat);
    end
  endtask

  task automatic test_sweep;
    int          sent [4];
    int          rcvd [4];
    int          cyc  = 0;
    logic        done = 1'b0;
    logic [33:0] e, g;
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      rcvd[i] = 0;
    end
    while (!done && cyc < 20000) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        s_out_ready[i] = ($urandom_range(0, 3) != 0);
        if (sent[i] < 1000) begin
          s_in_valid[i] = ($urandom_range(0, 3) != 0);
          s_a[i]   = $urandom();
          s_b[i]   = $urandom();
          s_cin[i] = 1'($urandom_range(0, 1));
          s_sub[i] = 1'($urandom_range(0, 1));
        end else begin
          s_in_valid[i] = 1'b0;
        end
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (s_in_valid[i] && s_in_ready[i]) begin
          expq[i].push_back(ref_calc(sw(i), s_a[i], s_b[i], s_cin[i], s_sub[i]));
          sent[i]++;
        end
        if (s_out_valid[i] && s_out_ready[i]) begin
          vectors++;
          g = {s_ovf[i], s_cout[i], s_y[i]};
          if (expq[i].size() == 0) begin
            miscompares++;
            $display("FAIL sweep%0d_extra: unexpected result %h", i, g);
          end else begin
            e = expq[i].pop_front();
            if (g !== e) begin
              miscompares++;
              $display("FAIL sweep%0d_result[%0d]: got ovf/cout/y=%h, need %h", i, rcvd[i], g, e);
            end
          end
          rcvd[i]++;
        end
      end
      done = 1'b1;
      for (int i = 0; i < 4; i++) if (rcvd[i] < 1000) done = 1'b0;
      cyc++;
    end
    s_in_valid = '0;
    s_out_ready = '1;
    $display("sweep finished after %0d cycles", cyc);
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL sweep_timeout: received %0d/%0d/%0d/%0d, need 1000 each", rcvd[0], rcvd[1], rcvd[2], rcvd[3]);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_sweep_latency;
    int          lat_i [4];
    logic [33:0] cap [4];
    logic [33:0] e;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      s_in_valid[i] = 1'b1; s_out_ready[i] = 1'b1;
      s_a[i] = 32'h89AB_CDEF; s_b[i] = 32'h7654_3210; s_cin[i] = 1'b1; s_sub[i] = 1'(i % 2);
      lat_i[i] = -1;
      cap[i] = '0;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (s_in_ready[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL lat%0d_in_ready: got %b, need 1", i, s_in_ready[i]);
      end
    end
    @(negedge clk);
    s_in_valid = '0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      for (int i = 0; i < 4; i++) begin
        if (lat_i[i] < 0 && s_out_valid[i]) begin
          lat_i[i] = c;
          cap[i] = {s_ovf[i], s_cout[i], s_y[i]};
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      e = ref_calc(sw(i), 32'h89AB_CDEF, 32'h7654_3210, 1'b1, 1'(i % 2));
      $display("probe W=%0d S=%0d lat=%0d result=%h", sw(i), ss(i), lat_i[i], cap[i]);
      vectors++;
      if (lat_i[i] !== ss(i) || cap[i] !== e) begin
        miscompares++;
        $display("FAIL lat%0d: got latency %0d result %h, need %0d %h", i, lat_i[i], cap[i], ss(i), e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_in_valid = '0; s_out_ready = '0; s_cin = '0; s_sub = '0;
    for (int i = 0; i < 4; i++) begin
      s_a[i] = '0;
      s_b[i] = '0;
    end
    test_reset;
    test_basic;
    test_arith;
    test_back_to_back;
    test_reset_midflight;
    test_sweep;
    test_sweep_latency;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
